// File: rtl/avalon_sram_dma_engine.sv
// avalon_sram_dma_engine
// Moves a programmable number of words between a local sample buffer (an
// external single-port SRAM with one cycle of read latency) and system memory.
// An Avalon-MM slave fills/reads the buffer and programs the engine, and an
// Avalon-MM master performs the transfers.
//   write-out (mode 0): buffer -> memory, read-in (mode 1): memory -> buffer.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   slave_*                     Avalon-MM slave, fixed read latency 1.
//                               Address MSB=0: buffer word, MSB=1: register
//                               (0 CTRL, 1 BASE, 2 COUNT, 3 STATUS)
//   master_*                    Avalon-MM master with waitrequest and
//                               readdatavalid, one read outstanding
//   buf_*                       SRAM port; buf_q returns one cycle after buf_rden
//   irq                         done AND irq_en
module avalon_sram_dma_engine #(
    parameter int MASTER_ADDR_W = 32,
    parameter int DATA_W        = 32,
    parameter int SAMPLE_W      = 16,
    parameter int DEPTH         = 512,
    parameter int BUF_ADDR_W    = $clog2(DEPTH),
    parameter int SLAVE_ADDR_W  = BUF_ADDR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     slave_chipselect,
    input  logic                     slave_read,
    input  logic                     slave_write,
    input  logic [SLAVE_ADDR_W-1:0]  slave_address,
    input  logic [DATA_W-1:0]        slave_writedata,
    output logic [DATA_W-1:0]        slave_readdata,
    output logic                     slave_readdatavalid,
    output logic [MASTER_ADDR_W-1:0] master_address,
    output logic                     master_write,
    output logic                     master_read,
    output logic [DATA_W-1:0]        master_writedata,
    input  logic [DATA_W-1:0]        master_readdata,
    input  logic                     master_readdatavalid,
    input  logic                     master_waitrequest,
    output logic                     buf_wren,
    output logic                     buf_rden,
    output logic [BUF_ADDR_W-1:0]    buf_address,
    output logic [SAMPLE_W-1:0]      buf_data,
    input  logic [SAMPLE_W-1:0]      buf_q,
    output logic                     irq
);

    // idx/count carry one extra bit so that a full-depth count is representable
    localparam int IDX_W = BUF_ADDR_W + 1;
    localparam logic [IDX_W-1:0]         ZERO_I  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]         ONE_I   = IDX_W'(1);
    localparam logic [IDX_W-1:0]         DEPTH_I = IDX_W'(DEPTH);
    localparam logic [DATA_W-1:0]        DEPTH_D = DATA_W'(DEPTH);
    localparam logic [MASTER_ADDR_W-1:0] BYTES_A = MASTER_ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_WR_REQ  = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_STORE   = 3'd6
    } state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q, cnt_q;
    logic [MASTER_ADDR_W-1:0]   xbase_q, m_addr_q;
    logic [SAMPLE_W-1:0]        rdata_q;
    logic [DATA_W-1:0]          m_wdata_q;
    logic                       m_write_q, m_read_q;
    logic                       mode_q, irq_en_q, done_q, err_q;
    logic [MASTER_ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]          count_q, s_rdata_q, reg_rdata_s;
    logic                       s_rvalid_q, s_rbuf_q;

    logic                       busy_s, rd_s, wr_s, reg_sel_s, start_s, last_s;
    logic                       finish_s, violation_s;
    logic [1:0]                 reg_idx_s;
    logic [IDX_W-1:0]           cnt_clamp_s, idx_inc_s;

    assign busy_s      = (state_q != S_IDLE);
    assign rd_s        = slave_chipselect & slave_read;
    assign wr_s        = slave_chipselect & slave_write;
    assign reg_sel_s   = slave_address[SLAVE_ADDR_W-1];
    assign reg_idx_s   = slave_address[1:0];
    assign start_s     = wr_s & reg_sel_s & (reg_idx_s == 2'd0) & slave_writedata[0] & ~busy_s;
    assign cnt_clamp_s = (count_q > DEPTH_D) ? DEPTH_I : IDX_W'(count_q);
    assign idx_inc_s   = idx_q + ONE_I;
    assign last_s      = (idx_inc_s >= cnt_q);
    // A word retires when the master write is accepted or the read-in word is stored
    assign finish_s    = last_s & (((state_q == S_WR_REQ) & ~master_waitrequest) |
                                   (state_q == S_STORE));
    // While busy the SRAM and programming registers belong to the engine
    assign violation_s = busy_s & ((~reg_sel_s & (rd_s | wr_s)) |
                                   (reg_sel_s & wr_s & (reg_idx_s != 2'd3)));

    // Register readback mux; buffer reads are returned from buf_q instead
    always_comb begin
        reg_rdata_s = {DATA_W{1'b0}};
        if (rd_s && reg_sel_s) begin
            case (reg_idx_s)
                2'd0:    reg_rdata_s = DATA_W'({irq_en_q, mode_q, 1'b0});
                2'd1:    reg_rdata_s = DATA_W'(base_q);
                2'd2:    reg_rdata_s = count_q;
                2'd3:    reg_rdata_s = DATA_W'({err_q, done_q, busy_s});
                default: reg_rdata_s = {DATA_W{1'b0}};
            endcase
        end else begin
            reg_rdata_s = {DATA_W{1'b0}};
        end
    end

    // SRAM port: engine owns it while busy, the slave only while idle
    always_comb begin
        buf_wren    = 1'b0;
        buf_rden    = 1'b0;
        buf_address = {BUF_ADDR_W{1'b0}};
        buf_data    = {SAMPLE_W{1'b0}};
        case (state_q)
            S_FETCH: begin
                buf_rden    = 1'b1;
                buf_address = idx_q[BUF_ADDR_W-1:0];
            end
            S_STORE: begin
                buf_wren    = 1'b1;
                buf_address = idx_q[BUF_ADDR_W-1:0];
                buf_data    = rdata_q;
            end
            S_IDLE: begin
                if (!reg_sel_s && (rd_s || wr_s)) begin
                    buf_rden    = rd_s;
                    buf_wren    = wr_s & ~rd_s;
                    buf_address = slave_address[BUF_ADDR_W-1:0];
                    buf_data    = slave_writedata[SAMPLE_W-1:0];
                end else begin
                    buf_rden = 1'b0;
                end
            end
            default: buf_rden = 1'b0;
        endcase
    end

    // Transfer FSM with registered master-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= ZERO_I;
            cnt_q     <= ZERO_I;
            xbase_q   <= {MASTER_ADDR_W{1'b0}};
            m_addr_q  <= {MASTER_ADDR_W{1'b0}};
            m_wdata_q <= {DATA_W{1'b0}};
            rdata_q   <= {SAMPLE_W{1'b0}};
            m_write_q <= 1'b0;
            m_read_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s && (cnt_clamp_s != ZERO_I)) begin
                        idx_q   <= ZERO_I;
                        cnt_q   <= cnt_clamp_s;
                        xbase_q <= base_q;
                        if (slave_writedata[1]) begin
                            m_addr_q <= base_q;
                            m_read_q <= 1'b1;
                            state_q  <= S_RD_REQ;
                        end else begin
                            state_q  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    m_wdata_q <= DATA_W'(buf_q);
                    m_addr_q  <= xbase_q + (MASTER_ADDR_W'(idx_q) * BYTES_A);
                    m_write_q <= 1'b1;
                    state_q   <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (!master_waitrequest) begin
                        m_write_q <= 1'b0;
                        if (last_s) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_inc_s;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (!master_waitrequest) begin
                        m_read_q <= 1'b0;
                        state_q  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        rdata_q <= master_readdata[SAMPLE_W-1:0];
                        state_q <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (last_s) begin
                        state_q <= S_IDLE;
                    end else begin
                        idx_q    <= idx_inc_s;
                        m_addr_q <= xbase_q + (MASTER_ADDR_W'(idx_inc_s) * BYTES_A);
                        m_read_q <= 1'b1;
                        state_q  <= S_RD_REQ;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    m_write_q <= 1'b0;
                    m_read_q  <= 1'b0;
                end
            endcase
        end
    end

    // Slave register file, status flags and latency-1 read response
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            base_q     <= {MASTER_ADDR_W{1'b0}};
            count_q    <= {DATA_W{1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            s_rdata_q  <= {DATA_W{1'b0}};
            s_rvalid_q <= 1'b0;
            s_rbuf_q   <= 1'b0;
        end else begin
            s_rvalid_q <= rd_s;
            s_rbuf_q   <= rd_s & ~reg_sel_s & ~busy_s;
            s_rdata_q  <= reg_rdata_s;
            if (wr_s && reg_sel_s && !busy_s) begin
                case (reg_idx_s)
                    2'd0: begin
                        mode_q   <= slave_writedata[1];
                        irq_en_q <= slave_writedata[2];
                    end
                    2'd1:    base_q  <= MASTER_ADDR_W'(slave_writedata);
                    2'd2:    count_q <= slave_writedata;
                    default: count_q <= count_q;
                endcase
            end
            if (violation_s) begin
                err_q <= 1'b1;
            end else if (wr_s && reg_sel_s && (reg_idx_s == 2'd3) && slave_writedata[2]) begin
                err_q <= 1'b0;
            end
            // Completion wins over a simultaneous W1C of done
            if (finish_s || (start_s && (cnt_clamp_s == ZERO_I))) begin
                done_q <= 1'b1;
            end else if (start_s) begin
                done_q <= 1'b0;
            end else if (wr_s && reg_sel_s && (reg_idx_s == 2'd3) && slave_writedata[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    assign slave_readdata      = s_rbuf_q ? DATA_W'(buf_q) : s_rdata_q;
    assign slave_readdatavalid = s_rvalid_q;
    assign master_address      = m_addr_q;
    assign master_write        = m_write_q;
    assign master_read         = m_read_q;
    assign master_writedata    = m_wdata_q;
    assign irq                 = done_q & irq_en_q;

endmodule

// File: doc/avalon_sram_dma_engine.md
Name: avalon_sram_dma_engine

Overview:
- Parametrised successor to the custom master/slave block: an Avalon-MM slave fills and controls a local sample buffer (external single-port SRAM), and an Avalon-MM master moves a programmable number of words between that buffer and system memory.
- Two modes: write-out (buffer -> memory) and read-in (memory -> buffer).
- Sits between the HPS/Avalon fabric and the FFT sample SRAM.
- Adds programmable base/count, waitrequest/readdatavalid handshaking, status, error and interrupt.

Parameters:
- MASTER_ADDR_W, 32, master byte-address width
- DATA_W, 32, Avalon data width; must be a multiple of 8 and >= SAMPLE_W
- SAMPLE_W, 16, SRAM word width
- DEPTH, 512, buffer words; power of 2
- BUF_ADDR_W, $clog2(DEPTH), buffer address width
- SLAVE_ADDR_W, BUF_ADDR_W+1, slave word-address width; MSB selects the register bank

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- slave_chipselect  in  1  slave select
- slave_read  in  1  slave read strobe
- slave_write  in  1  slave write strobe
- slave_address  in  SLAVE_ADDR_W  MSB=0: buffer word; MSB=1: register (low 2 bits)
- slave_writedata  in  DATA_W  slave write data
- slave_readdata  out  DATA_W  slave read data
- slave_readdatavalid  out  1  one-cycle pulse, fixed read latency of 1
- master_address  out  MASTER_ADDR_W  byte address
- master_write  out  1  master write request
- master_read  out  1  master read request
- master_writedata  out  DATA_W  master write data
- master_readdata  in  DATA_W  master read data
- master_readdatavalid  in  1  read data valid
- master_waitrequest  in  1  stall
- buf_wren  out  1  SRAM write enable
- buf_rden  out  1  SRAM read enable; data returns on buf_q one cycle later
- buf_address  out  BUF_ADDR_W  SRAM address
- buf_data  out  SAMPLE_W  SRAM write data
- buf_q  in  SAMPLE_W  SRAM read data
- irq  out  1  done AND irq_en

Behaviour:
- Slave accesses occur only when chipselect is high.
- Registers (bank MSB=1):
  - 0 CTRL: bit0 start (self-clearing), bit1 mode (0 = write-out, 1 = read-in), bit2 irq_en
  - 1 BASE: master byte address
  - 2 COUNT: word count
  - 3 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C)
- Reset: all registers 0; all outputs 0; FSM in IDLE.
- Slave read: slave_readdata/slave_readdatavalid are registered (latency 1).
  - Buffer read: buf_rden is issued in the request cycle; buf_q is zero-extended.
  - Buffer read while busy returns 0, valid still pulses, err is set.
- Slave buffer write while idle: buf_wren in the same cycle, buf_data = writedata[SAMPLE_W-1:0].
- Slave buffer write while busy: ignored, err set.
- Writes to CTRL, BASE or COUNT while busy: ignored, err set. STATUS W1C is always honoured.
- Start (write CTRL with bit0=1 while idle):
  - Latch mode, BASE and min(COUNT, DEPTH); idx = 0; done cleared; busy = 1 next cycle.
  - COUNT = 0: done sets next cycle and busy never asserts.
- FSM states: IDLE, FETCH, LOAD, WR_REQ, RD_REQ, RD_WAIT, STORE.
- Write-out word sequence:
  - FETCH: buf_rden, buf_address = idx.
  - LOAD: latch zero-extended buf_q into master_writedata.
  - WR_REQ: master_write = 1, master_address = BASE + idx*(DATA_W/8). Hold address/data/write stable while waitrequest is high; the word completes on the rising edge where waitrequest is low.
  - Then idx++. Go to FETCH if idx < count, else IDLE with done = 1.
  - Minimum 3 cycles per word.
- Read-in word sequence:
  - RD_REQ: master_read held until waitrequest is low.
  - RD_WAIT: wait for readdatavalid; only one read outstanding.
  - STORE: buf_wren, buf_address = idx, buf_data = readdata[SAMPLE_W-1:0]; idx++; loop or finish as in write-out.
- Address arithmetic wraps modulo 2^MASTER_ADDR_W; idx never exceeds DEPTH-1.
- Reset mid-transfer: abort on the next edge; master_read/master_write drop; nothing further is written.
- Simultaneous slave W1C of done and completion in the same cycle: done remains set.
- irq is combinational from registered done and irq_en.

Test Plan:
- Reset, then slave-write buffer[i] = i for i = 0..255; COUNT = 256, BASE = 0x1000, mode 0, start; waitrequest high 3 cycles per word -> 256 master writes, address 0x1000 + 4i, data i, stable during stall; done = 1, busy = 0.
- Write-out with waitrequest tied low -> each word takes exactly 3 cycles; total busy time 3*COUNT cycles.
- Read-in, COUNT = 4, memory returns 0xABCD0001..0xABCD0004 with readdatavalid 2 cycles after accept -> buffer[0..3] = 0x0001..0x0004; slave readback of the buffer matches.
- COUNT = 0 -> done next cycle, no master strobes. COUNT = 1000 -> exactly 512 transfers.
- Slave write to buffer and to BASE while busy -> buffer/BASE unchanged, err = 1; W1C 0x4 to STATUS -> err = 0; irq_en = 1 -> irq asserts with done, and W1C 0x2 clears it.
- Assert rst during word 10 of a write-out -> next cycle master_write = 0, all registers 0, FSM in IDLE; a fresh start then runs correctly.
